// File: rtl/execute_pkg.sv
// Shared execute-stage definitions: operand select codes, forwarding FSM states
// and the destination tag record carried down the EX/MEM/WB tag pipeline.
package execute_pkg;

    localparam int unsigned SEL_CODE_W = 3;
    localparam int unsigned TAG_RD_W   = 8;

    localparam logic [SEL_CODE_W-1:0] SEL_RF  = 3'b000;
    localparam logic [SEL_CODE_W-1:0] SEL_EX  = 3'b001;
    localparam logic [SEL_CODE_W-1:0] SEL_MEM = 3'b010;
    localparam logic [SEL_CODE_W-1:0] SEL_WB  = 3'b011;
    localparam logic [SEL_CODE_W-1:0] SEL_PC  = 3'b100;
    localparam logic [SEL_CODE_W-1:0] SEL_IMM = 3'b101;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2
    } fwd_state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                wen;
        logic                is_load;
    } tag_t;

    localparam tag_t TAG_NONE = '0;

    // A tag supplies a source only if it really writes that (non-x0) register.
    function automatic logic tag_hit(input tag_t t, input logic [TAG_RD_W-1:0] src,
                                     input logic src_use);
        return t.valid && t.wen && src_use && (src != '0) && (t.rd == src);
    endfunction

endpackage

// File: rtl/forward_match.sv
// Per-operand select resolution against the EX/MEM/WB tags.
// WB bypass (code 011) is only considered when FWD_WB_BYPASS_EN is defined.
module forward_match
    import execute_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input  logic [TAG_RD_W-1:0]   src_addr,
    input  logic                  src_use,
    input  logic                  override,
    input  logic [SEL_CODE_W-1:0] override_code,
    input  tag_t                  tag_ex,
    input  tag_t                  tag_mem,
    input  tag_t                  tag_wb,
    output logic [SEL_W-1:0]      sel_c,
    output logic                  load_use_c
);

    logic unused_c;

    // Youngest producer wins; PC/immediate operands bypass forwarding entirely.
    always_comb begin
        sel_c = SEL_W'(SEL_RF);
        if (override) begin
            sel_c = SEL_W'(override_code);
        end else if (tag_hit(tag_ex, src_addr, src_use)) begin
            sel_c = SEL_W'(SEL_EX);
        end else if (tag_hit(tag_mem, src_addr, src_use)) begin
            sel_c = SEL_W'(SEL_MEM);
`ifdef FWD_WB_BYPASS_EN
        end else if (tag_hit(tag_wb, src_addr, src_use)) begin
            sel_c = SEL_W'(SEL_WB);
`endif
        end
    end

    assign load_use_c = tag_ex.is_load && tag_hit(tag_ex, src_addr, src_use);

`ifdef FWD_WB_BYPASS_EN
    assign unused_c = tag_mem.is_load ^ tag_wb.is_load;
`else
    assign unused_c = ^{tag_mem.is_load, tag_wb};
`endif

endmodule

// File: rtl/operand_forward_ctrl.sv
// Operand forwarding / load-use interlock controller for the execute stage.
// Optional WB-data bypass enabled by defining FWD_WB_BYPASS_EN.
module operand_forward_ctrl
    import execute_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned SEL_W      = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ID_VALID,
    input  logic [REG_ADDR_W-1:0] RS1_ADDR,
    input  logic [REG_ADDR_W-1:0] RS2_ADDR,
    input  logic                  RS1_USE,
    input  logic                  RS2_USE,
    input  logic                  OP1_PC,
    input  logic                  OP2_IMM,
    input  logic [REG_ADDR_W-1:0] RD_ADDR,
    input  logic                  RD_WEN,
    input  logic                  IS_LOAD,
    input  logic                  FREEZE,
    output logic [SEL_W-1:0]      SEL1,
    output logic [SEL_W-1:0]      SEL2,
    output logic                  STALL
);

    fwd_state_e       state_q, state_d, prior_q, prior_d, eff_state_c;
    tag_t             tag_ex_q, tag_ex_d, tag_mem_q, tag_mem_d, tag_wb_q, tag_wb_d;
    tag_t             dec_tag_c;
    logic [SEL_W-1:0] sel1_q, sel1_d, sel2_q, sel2_d, sel1_c, sel2_c;
    logic             stall_q, stall_d;
    logic             load_use1_c, load_use2_c, hazard_c;

    always_comb begin
        dec_tag_c         = TAG_NONE;
        dec_tag_c.valid   = ID_VALID;
        dec_tag_c.rd      = TAG_RD_W'(RD_ADDR);
        dec_tag_c.wen     = RD_WEN;
        dec_tag_c.is_load = IS_LOAD;
    end

    forward_match #(.SEL_W(SEL_W)) u_match1 (
        .src_addr      (TAG_RD_W'(RS1_ADDR)),
        .src_use       (RS1_USE),
        .override      (OP1_PC),
        .override_code (SEL_PC),
        .tag_ex        (tag_ex_q),
        .tag_mem       (tag_mem_q),
        .tag_wb        (tag_wb_q),
        .sel_c         (sel1_c),
        .load_use_c    (load_use1_c)
    );

    forward_match #(.SEL_W(SEL_W)) u_match2 (
        .src_addr      (TAG_RD_W'(RS2_ADDR)),
        .src_use       (RS2_USE),
        .override      (OP2_IMM),
        .override_code (SEL_IMM),
        .tag_ex        (tag_ex_q),
        .tag_mem       (tag_mem_q),
        .tag_wb        (tag_wb_q),
        .sel_c         (sel2_c),
        .load_use_c    (load_use2_c)
    );

    assign hazard_c = ID_VALID && (load_use1_c || load_use2_c);

    // Leaving HOLD behaves exactly like the state that was frozen.
    assign eff_state_c = (state_q == ST_HOLD) ? prior_q : state_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            prior_q <= ST_RUN;
        end else begin
            state_q <= state_d;
            prior_q <= prior_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prior_d = prior_q;
        if (FREEZE) begin
            state_d = ST_HOLD;
            prior_d = eff_state_c;
        end else begin
            case (eff_state_c)
                ST_RUN:  state_d = hazard_c ? ST_STALL : ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Tag pipeline advance and registered select/stall outputs.
    always_comb begin
        tag_ex_d  = tag_ex_q;
        tag_mem_d = tag_mem_q;
        tag_wb_d  = tag_wb_q;
        sel1_d    = sel1_q;
        sel2_d    = sel2_q;
        stall_d   = stall_q;
        if (!FREEZE) begin
            tag_wb_d  = tag_mem_q;
            tag_mem_d = tag_ex_q;
            stall_d   = 1'b0;
            if ((eff_state_c == ST_RUN) && hazard_c) begin
                tag_ex_d = TAG_NONE;
                sel1_d   = SEL_W'(SEL_RF);
                sel2_d   = SEL_W'(SEL_RF);
                stall_d  = 1'b1;
            end else if (ID_VALID) begin
                tag_ex_d = dec_tag_c;
                sel1_d   = sel1_c;
                sel2_d   = sel2_c;
            end else begin
                tag_ex_d = TAG_NONE;
                sel1_d   = SEL_W'(SEL_RF);
                sel2_d   = SEL_W'(SEL_RF);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_ex_q  <= TAG_NONE;
            tag_mem_q <= TAG_NONE;
            tag_wb_q  <= TAG_NONE;
            sel1_q    <= SEL_W'(SEL_RF);
            sel2_q    <= SEL_W'(SEL_RF);
            stall_q   <= 1'b0;
        end else begin
            tag_ex_q  <= tag_ex_d;
            tag_mem_q <= tag_mem_d;
            tag_wb_q  <= tag_wb_d;
            sel1_q    <= sel1_d;
            sel2_q    <= sel2_d;
            stall_q   <= stall_d;
        end
    end

    assign SEL1  = sel1_q;
    assign SEL2  = sel2_q;
    assign STALL = stall_q;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed-vector bench for operand_forward_ctrl; expected selects are hand-derived
// from instruction spacing (WB case depends on FWD_WB_BYPASS_EN).
module tb_operand_forward_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       ID_VALID, RS1_USE, RS2_USE, OP1_PC, OP2_IMM, RD_WEN, IS_LOAD, FREEZE;
    logic [4:0] RS1_ADDR, RS2_ADDR, RD_ADDR;
    logic [2:0] SEL1, SEL2;
    logic       STALL;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FWD_WB_BYPASS_EN
    localparam logic [2:0] EXP_WB = 3'b011;
`else
    localparam logic [2:0] EXP_WB = 3'b000;
`endif

    operand_forward_ctrl #(.REG_ADDR_W(5), .SEL_W(3)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ID_VALID (ID_VALID),
        .RS1_ADDR (RS1_ADDR),
        .RS2_ADDR (RS2_ADDR),
        .RS1_USE  (RS1_USE),
        .RS2_USE  (RS2_USE),
        .OP1_PC   (OP1_PC),
        .OP2_IMM  (OP2_IMM),
        .RD_ADDR  (RD_ADDR),
        .RD_WEN   (RD_WEN),
        .IS_LOAD  (IS_LOAD),
        .FREEZE   (FREEZE),
        .SEL1     (SEL1),
        .SEL2     (SEL2),
        .STALL    (STALL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input logic [2:0] s1, input logic [2:0] s2,
                              input logic st);
        check({tag, ".sel1"},  32'(SEL1),  32'(s1));
        check({tag, ".sel2"},  32'(SEL2),  32'(s2));
        check({tag, ".stall"}, 32'(STALL), 32'(st));
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic pc,
                         input logic imm, input logic [4:0] rd, input logic wen,
                         input logic ld);
        ID_VALID = v;  RS1_ADDR = r1; RS1_USE = u1; RS2_ADDR = r2; RS2_USE = u2;
        OP1_PC   = pc; OP2_IMM  = imm; RD_ADDR = rd; RD_WEN  = wen; IS_LOAD = ld;
    endtask

    // ALU op rd <- rs1, rs2
    task automatic alu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b1, r1, 1'b1, r2, 1'b1, 1'b0, 1'b0, rd, 1'b1, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        RST_N  = 1'b0;
        FREEZE = 1'b0;
        idle();
        #3;
        expect_out("reset", 3'b000, 3'b000, 1'b0);
        tick();
        tick();
        RST_N = 1'b1;

        // back-to-back ALU dependency forwards from EX/MEM
        alu(5'd5, 5'd1, 5'd2);                 tick();
        expect_out("add1", 3'b000, 3'b000, 1'b0);
        alu(5'd6, 5'd5, 5'd1);                 tick();
        expect_out("add_dep", 3'b001, 3'b000, 1'b0);
        flush();

        // load-use: one stall cycle with bubble, then MEM/WB forwarding
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        alu(5'd8, 5'd7, 5'd7);                 tick();
        expect_out("lu_stall", 3'b000, 3'b000, 1'b1);
        tick();
        expect_out("lu_resume", 3'b010, 3'b010, 1'b0);
        flush();

        // producer three ahead (WB), MEM distance and EX-over-MEM priority
        alu(5'd9, 5'd1, 5'd2);                 tick();
        alu(5'd10, 5'd1, 5'd2);                tick();
        alu(5'd11, 5'd1, 5'd2);                tick();
        alu(5'd12, 5'd9, 5'd10);               tick();
        expect_out("wb_dist", EXP_WB, 3'b010, 1'b0);
        alu(5'd14, 5'd1, 5'd2);                tick();
        alu(5'd14, 5'd1, 5'd2);                tick();
        alu(5'd13, 5'd14, 5'd14);              tick();
        expect_out("ex_prio", 3'b001, 3'b001, 1'b0);
        flush();

        // x0 never forwards; PC/immediate override a live match
        alu(5'd0, 5'd1, 5'd2);                 tick();
        alu(5'd0, 5'd1, 5'd2);                 tick();
        alu(5'd3, 5'd0, 5'd0);                 tick();
        expect_out("x0", 3'b000, 3'b000, 1'b0);
        flush();
        alu(5'd15, 5'd1, 5'd2);                tick();
        drive(1'b1, 5'd15, 1'b1, 5'd15, 1'b1, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0); tick();
        expect_out("op1_pc", 3'b100, 3'b001, 1'b0);
        drive(1'b1, 5'd15, 1'b1, 5'd15, 1'b1, 1'b0, 1'b1, 5'd17, 1'b1, 1'b0); tick();
        expect_out("op2_imm", 3'b010, 3'b101, 1'b0);
        drive(1'b1, 5'd15, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 5'd18, 1'b1, 1'b0); tick();
        expect_out("rs_use", 3'b000, 3'b010, 1'b0);
        flush();

        // ID_VALID low inserts a bubble into EX
        alu(5'd20, 5'd1, 5'd2);                tick();
        drive(1'b0, 5'd20, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        expect_out("bubble", 3'b000, 3'b000, 1'b0);
        alu(5'd21, 5'd20, 5'd1);               tick();
        expect_out("post_bubble", 3'b010, 3'b000, 1'b0);
        flush();

        // FREEZE for 3 cycles in the middle of a load-use stall
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        alu(5'd8, 5'd7, 5'd7);                 tick();
        expect_out("fz_stall", 3'b000, 3'b000, 1'b1);
        FREEZE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("fz_hold%0d", i), 3'b000, 3'b000, 1'b1);
        end
        FREEZE = 1'b0;
        tick();
        expect_out("fz_release", 3'b010, 3'b010, 1'b0);
        flush();

        // FREEZE together with a fresh hazard: hold first, stall after release
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        alu(5'd8, 5'd7, 5'd7);
        FREEZE = 1'b1;                         tick();
        expect_out("fzhz_hold", 3'b000, 3'b000, 1'b0);
        FREEZE = 1'b0;                         tick();
        expect_out("fzhz_stall", 3'b000, 3'b000, 1'b1);
        tick();
        expect_out("fzhz_resume", 3'b010, 3'b010, 1'b0);
        flush();

        // Reset in the middle of a stall
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        alu(5'd8, 5'd7, 5'd7);                 tick();
        expect_out("rst_pre", 3'b000, 3'b000, 1'b1);
        alu(5'd5, 5'd1, 5'd2);                 tick();
        alu(5'd8, 5'd5, 5'd5);                 tick();
        expect_out("rst_fwd", 3'b001, 3'b001, 1'b0);
        RST_N = 1'b0;
        #2;
        expect_out("rst_async", 3'b000, 3'b000, 1'b0);
        tick();
        RST_N = 1'b1;
        alu(5'd8, 5'd7, 5'd5);                 tick();
        expect_out("rst_after", 3'b000, 3'b000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
